ex_stage_unit: RTL

//  Execute stage; consumes the registered ID/EX control and operand fields each clk.

---
 rtl/ex_pkg.sv | 15 +
 rtl/ex_muldiv.sv | 106 ++++++++++
 rtl/ex_stage_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared encodings and default widths for the execute stage.
package ex_pkg;
  localparam int EX_DATA_W = 16;
  localparam int EX_OFF_W  = 8;
  localparam int EX_REG_W  = 4;

  typedef enum logic [1:0] {UF_ALU = 2'b00, UF_ADDR, UF_PASS2, UF_PASS1} use_func_e;

  typedef enum logic [3:0] {
    F_ADD = 4'd0, F_SUB, F_AND, F_OR, F_XOR, F_NOT, F_MUL, F_DIV,
    F_SLL, F_SRL, F_SRA, F_ROL
  } func_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_e;
endpackage

// File: rtl/ex_muldiv.sv
// Iterative signed multiply / restoring divide on operand magnitudes.
// A single FIX cycle applies the signs; done pulses one cycle with lo/hi valid.
module ex_muldiv import ex_pkg::*; #(
  parameter int W = EX_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic         flush,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  md_state_e      state;
  logic [CW-1:0]  cnt;
  logic           op_div, sa, sb, bz;
  logic [W-1:0]   acc, q, mag_b, a_raw;
  logic [W:0]     mul_sum, div_shift;
  logic           div_ge;
  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_lo, fix_hi;

  // mul: {acc,q} is the shifting product, q starts as |A|; div: acc is the remainder, q the quotient
  always_comb begin
    mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc, q[W-1]};
    div_ge    = div_shift >= {1'b0, mag_b};
    prod      = (sa ^ sb) ? -{acc, q} : {acc, q};
    fix_lo    = prod[W-1:0];
    fix_hi    = prod[2*W-1:W];
    if (op_div) begin
      if (bz) begin
        fix_lo = '1;
        fix_hi = a_raw;
      end else begin
        fix_lo = (sa ^ sb) ? -q : q;
        fix_hi = sa ? -acc : acc;
      end
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
      acc    <= '0;
      q      <= '0;
      mag_b  <= '0;
      a_raw  <= '0;
      done   <= 1'b0;
      lo     <= '0;
      hi     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) state <= ST_IDLE;
      else begin
        case (state)
          ST_IDLE: if (start) begin
            state  <= is_div ? ST_DIV : ST_MUL;
            op_div <= is_div;
            cnt    <= '0;
            sa     <= a[W-1];
            sb     <= b[W-1];
            bz     <= (b == '0);
            a_raw  <= a;
            acc    <= '0;
            q      <= a[W-1] ? -a : a;
            mag_b  <= b[W-1] ? -b : b;
          end
          ST_MUL: begin
            acc <= mul_sum[W:1];
            q   <= {mul_sum[0], q[W-1:1]};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= ST_FIX;
          end
          ST_DIV: begin
            acc <= div_ge ? (div_shift[W-1:0] - mag_b) : div_shift[W-1:0];
            q   <= {q[W-2:0], div_ge};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= ST_FIX;
          end
          ST_FIX: begin
            lo    <= fix_lo;
            hi    <= fix_hi;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: single-cycle ALU/shift/address ops, iterative mul/div with upstream stall,
// registered EX/MEM outputs with forwarded MEM/WB control.
module ex_stage_unit import ex_pkg::*; #(
  parameter int DATA_W = EX_DATA_W,
  parameter int OFF_W  = EX_OFF_W,
  parameter int REG_W  = EX_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  input  logic              flush,
  input  logic [1:0]        useFunc,
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [OFF_W-1:0]  offset,
  input  logic              offsetSel,
  input  logic [REG_W-1:0]  op1,
  input  logic [1:0]        rWrite,
  input  logic              mWrite,
  input  logic              mRead,
  input  logic              mByte,
  output logic              stall,
  output logic              exValid,
  output logic [DATA_W-1:0] exResult,
  output logic [DATA_W-1:0] exHi,
  output logic              exHiWrite,
  output logic [DATA_W-1:0] exStore,
  output logic [REG_W-1:0]  exDest,
  output logic [1:0]        rWriteOut,
  output logic              mWriteOut,
  output logic              mReadOut,
  output logic              mByteOut
);
  logic [DATA_W-1:0]   sext_off, op_b, alu_res, result;
  logic [2*DATA_W-1:0] rot2;
  logic [3:0]          sh;
  logic                md_op, accept, md_busy, md_done;
  logic [DATA_W-1:0]   md_lo, md_hi, hold_store;
  logic [REG_W-1:0]    hold_dest;
  logic [1:0]          hold_rw;
  logic                hold_mw, hold_mr, hold_mb;

  assign sext_off = {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign op_b     = offsetSel ? sext_off : data2;
  assign sh       = op_b[3:0];
  assign md_op    = (useFunc == UF_ALU) && (func == F_MUL || func == F_DIV);
  // the done cycle still sees the held mul/div in ID/EX, so it must not re-accept it
  assign accept   = rst_n && inValid && md_op && !md_busy && !md_done && !flush;
  assign stall    = accept || md_busy;

  always_comb begin
    rot2 = {data1, data1} << sh;
    case (func)
      F_ADD:   alu_res = data1 + op_b;
      F_SUB:   alu_res = data1 - op_b;
      F_AND:   alu_res = data1 & op_b;
      F_OR:    alu_res = data1 | op_b;
      F_XOR:   alu_res = data1 ^ op_b;
      F_NOT:   alu_res = ~data1;
      F_SLL:   alu_res = data1 << sh;
      F_SRL:   alu_res = data1 >> sh;
      F_SRA:   alu_res = DATA_W'($signed(data1) >>> sh);
      F_ROL:   alu_res = rot2[2*DATA_W-1:DATA_W];
      default: alu_res = data1;
    endcase
    case (useFunc)
      UF_ADDR:  result = data2 + sext_off;
      UF_PASS2: result = data2;
      UF_PASS1: result = data1;
      default:  result = alu_res;
    endcase
  end

  ex_muldiv #(.W(DATA_W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .is_div (func == F_DIV),
    .flush  (flush),
    .a      (data1),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {hold_store, hold_dest, hold_rw, hold_mw, hold_mr, hold_mb} <= '0;
      {exValid, exResult, exHi, exHiWrite, exStore, exDest}       <= '0;
      {rWriteOut, mWriteOut, mReadOut, mByteOut}                  <= '0;
    end else begin
      if (accept) begin
        hold_store <= data1;
        hold_dest  <= op1;
        hold_rw    <= rWrite;
        hold_mw    <= mWrite;
        hold_mr    <= mRead;
        hold_mb    <= mByte;
      end
      {exValid, exResult, exHi, exHiWrite, exStore, exDest} <= '0;
      {rWriteOut, mWriteOut, mReadOut, mByteOut}            <= '0;
      if (!flush) begin
        if (md_done) begin
          exValid   <= 1'b1;
          exResult  <= md_lo;
          exHi      <= md_hi;
          exHiWrite <= 1'b1;
          exStore   <= hold_store;
          exDest    <= hold_dest;
          rWriteOut <= hold_rw;
          mWriteOut <= hold_mw;
          mReadOut  <= hold_mr;
          mByteOut  <= hold_mb;
        end else if (inValid && !md_op && !md_busy) begin
          exValid   <= 1'b1;
          exResult  <= result;
          exStore   <= data1;
          exDest    <= op1;
          rWriteOut <= rWrite;
          mWriteOut <= mWrite;
          mReadOut  <= mRead;
          mByteOut  <= mByte;
        end
      end
    end
  end
endmodule
